// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer for the LC-3b pipeline.
// Takes the memory fields of the EX/MEM control word and runs the data-memory
// request/response handshake for word, byte and indirect (LDI/STI) accesses.
// The pipeline is held with stall while an access is in flight. It is then
// released for exactly one cycle (DONE), and load_data_valid is high in that
// cycle.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   valid, op_*           - control word present / access kind
//   addr, wdata           - effective address and store data from EX
//   dmem_rdata, dmem_resp - data cache read data and completion pulse
//   dmem_read/write       - level requests held until dmem_resp
//   dmem_address/wdata    - request address and write data
//   dmem_byte_enable      - per-byte write enables (0 unless writing)
//   stall                 - hold upstream pipeline registers
//   load_data(_valid)     - load result for MEM/WB, valid only in DONE
module mem_stage_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic        op_read,
   input  logic        op_write,
   input  logic        op_byte,
   input  logic        op_indirect,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [15:0] dmem_address,
   output logic [15:0] dmem_wdata,
   output logic [1:0]  dmem_byte_enable,
   output logic        stall,
   output logic [15:0] load_data,
   output logic        load_data_valid
);

   typedef enum logic [1:0] {IDLE, PTR, DATA, DONE} state_t;

   state_t      state;
   logic [15:0] lat_addr;
   logic [15:0] lat_wdata;
   logic        lat_byte;
   logic        lat_write;
   logic        lat_ind;

   logic        trigger;
   logic [7:0]  byte_sel;
   logic [15:0] read_result;

   always_comb begin
      trigger     = valid && (op_read || op_write);
      byte_sel    = lat_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
      read_result = lat_byte ? {{8{byte_sel[7]}}, byte_sel} : dmem_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_byte  <= 1'b0;
         lat_write <= 1'b0;
         lat_ind   <= 1'b0;
         load_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (trigger) begin
                  lat_addr  <= addr;
                  lat_wdata <= wdata;
                  lat_byte  <= op_byte;
                  // read+write together resolves to a write
                  lat_write <= op_write;
                  lat_ind   <= op_indirect;
                  state     <= op_indirect ? PTR : DATA;
               end
            end
            PTR: begin
               if (dmem_resp) begin
                  lat_addr <= dmem_rdata;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (dmem_resp) begin
                  if (!lat_write)
                     load_data <= read_result;
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Request outputs decode only registered state and latches.
   always_comb begin
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      dmem_address     = '0;
      dmem_wdata       = '0;
      dmem_byte_enable = '0;
      stall            = 1'b0;
      load_data_valid  = 1'b0;
      case (state)
         IDLE: stall = trigger && !reset;
         PTR: begin
            dmem_read    = 1'b1;
            dmem_address = {lat_addr[15:1], 1'b0};
            stall        = 1'b1;
         end
         DATA: begin
            dmem_read    = !lat_write;
            dmem_write   = lat_write;
            dmem_address = lat_byte ? lat_addr : {lat_addr[15:1], 1'b0};
            stall        = 1'b1;
            if (lat_byte) begin
               dmem_wdata = {lat_wdata[7:0], lat_wdata[7:0]};
               if (lat_write)
                  dmem_byte_enable = lat_addr[0] ? 2'b10 : 2'b01;
            end else begin
               dmem_wdata = lat_wdata;
               if (lat_write)
                  dmem_byte_enable = 2'b11;
            end
         end
         DONE: load_data_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl. Inputs change 1 time unit after the
// rising edge and outputs are sampled on the falling edge. A small cache
// driver answers each request phase after a chosen latency.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        reset, valid, op_read, op_write, op_byte, op_indirect;
   logic [15:0] addr, wdata, dmem_rdata;
   logic        dmem_resp;
   logic        dmem_read, dmem_write, stall, load_data_valid;
   logic [15:0] dmem_address, dmem_wdata, load_data;
   logic [1:0]  dmem_byte_enable;

   int checks = 0;
   int failures = 0;

   // observations gathered by do_access
   int          obs_stall, obs_done, obs_nvalid, obs_nresp, obs_both, obs_reqt;
   logic [15:0] obs_addr [2];
   logic [15:0] obs_wd   [2];
   logic [1:0]  obs_be   [2];
   logic        obs_wr   [2];
   logic [15:0] obs_ld;

   always #5 clk = ~clk;

   mem_stage_ctrl dut (
      .clk(clk), .reset(reset), .valid(valid), .op_read(op_read),
      .op_write(op_write), .op_byte(op_byte), .op_indirect(op_indirect),
      .addr(addr), .wdata(wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
      .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .stall(stall),
      .load_data(load_data), .load_data_valid(load_data_valid)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ops();
      valid = 0; op_read = 0; op_write = 0; op_byte = 0; op_indirect = 0;
      addr = 16'hFFFF; wdata = 16'h0000;
   endtask

   // Present one op for one cycle, then answer phase 0 after lat0 cycles
   // and phase 1 after lat1 cycles. Cycle numbers count from the trigger (0).
   task automatic do_access(input logic rd, input logic wr, input logic byt,
                            input logic ind, input logic [15:0] a,
                            input logic [15:0] wd, input int lat0,
                            input logic [15:0] rd0, input int lat1,
                            input logic [15:0] rd1);
      int age, ph;
      bit fin;
      obs_stall = 0; obs_done = -1; obs_nvalid = 0; obs_nresp = 0;
      obs_both = 0; obs_reqt = 0; obs_ld = 16'hxxxx;
      for (int i = 0; i < 2; i++) begin
         obs_addr[i] = 16'hxxxx; obs_wd[i] = 16'hxxxx;
         obs_be[i] = 2'bxx; obs_wr[i] = 1'bx;
      end
      step();
      valid = 1; op_read = rd; op_write = wr; op_byte = byt;
      op_indirect = ind; addr = a; wdata = wd;
      @(negedge clk);
      obs_stall += int'(stall);
      if (dmem_read || dmem_write) obs_reqt = 1;
      age = 0; ph = 0; fin = 0;
      for (int c = 1; c < 40 && !fin; c++) begin
         step();
         clear_ops();
         dmem_resp = 0;
         if (dmem_read && dmem_write) obs_both++;
         if (dmem_read || dmem_write) begin
            if (age == 0 && ph < 2) begin
               obs_addr[ph] = dmem_address; obs_wd[ph] = dmem_wdata;
               obs_be[ph] = dmem_byte_enable; obs_wr[ph] = dmem_write;
            end
            if (age == ((ph == 0) ? lat0 : lat1)) begin
               dmem_resp = 1;
               dmem_rdata = (ph == 0) ? rd0 : rd1;
               ph++; age = 0; obs_nresp++;
            end else begin
               age++;
            end
         end
         @(negedge clk);
         obs_stall += int'(stall);
         if (load_data_valid) begin
            obs_nvalid++; obs_done = c; obs_ld = load_data; fin = 1;
         end
      end
      step();
      dmem_resp = 0;
   endtask

   task automatic test_reset();
      reset = 1; valid = 1; op_read = 1; op_write = 0; op_byte = 0;
      op_indirect = 0; addr = 16'h1234; wdata = 16'h5678;
      dmem_resp = 0; dmem_rdata = 16'h0;
      for (int i = 0; i < 2; i++) begin
         step();
         @(negedge clk);
         checks++; if ({dmem_read, dmem_write, stall, load_data_valid} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", {dmem_read, dmem_write, stall, load_data_valid}); end
         checks++; if (dmem_address !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0000", dmem_address); end
      end
      step();
      reset = 0; clear_ops();
      @(negedge clk);
      checks++; if ({dmem_read, dmem_write, stall, load_data_valid, dmem_byte_enable} !== 6'b0) begin failures++; $display("FAIL post_reset_ctl got=%b exp=000000", {dmem_read, dmem_write, stall, load_data_valid, dmem_byte_enable}); end
      checks++; if (load_data !== 16'h0) begin failures++; $display("FAIL post_reset_ld got=%h exp=0000", load_data); end
   endtask

   task automatic test_non_mem();
      for (int i = 0; i < 3; i++) begin
         step();
         valid = 1; op_read = 0; op_write = 0; op_byte = i[0]; op_indirect = i[1];
         @(negedge clk);
         checks++; if ({stall, dmem_read, dmem_write} !== 3'b0) begin failures++; $display("FAIL non_mem got=%b exp=000", {stall, dmem_read, dmem_write}); end
      end
      step();
      clear_ops();
   endtask

   task automatic test_word_load();
      do_access(1, 0, 0, 0, 16'h3001, 16'h0, 2, 16'hBEEF, 0, 16'h0);
      checks++; if (obs_reqt !== 0) begin failures++; $display("FAIL wl_req_in_trigger got=%0d exp=0", obs_reqt); end
      checks++; if (obs_addr[0] !== 16'h3000) begin failures++; $display("FAIL wl_addr got=%h exp=3000", obs_addr[0]); end
      checks++; if (obs_be[0] !== 2'b00 || obs_wr[0] !== 1'b0) begin failures++; $display("FAIL wl_be_wr got=%b/%b exp=00/0", obs_be[0], obs_wr[0]); end
      checks++; if (obs_stall !== 4) begin failures++; $display("FAIL wl_stall got=%0d exp=4", obs_stall); end
      checks++; if (obs_done !== 4) begin failures++; $display("FAIL wl_done got=%0d exp=4", obs_done); end
      checks++; if (obs_ld !== 16'hBEEF || obs_nvalid !== 1) begin failures++; $display("FAIL wl_data got=%h/%0d exp=beef/1", obs_ld, obs_nvalid); end
      @(negedge clk);
      checks++; if (load_data_valid !== 1'b0) begin failures++; $display("FAIL wl_valid_one_cycle got=%b exp=0", load_data_valid); end
   endtask

   task automatic test_byte_store();
      do_access(0, 1, 1, 0, 16'h2005, 16'h12A7, 0, 16'h0, 0, 16'h0);
      checks++; if (obs_addr[0] !== 16'h2005 || obs_wr[0] !== 1'b1) begin failures++; $display("FAIL bs_addr got=%h/%b exp=2005/1", obs_addr[0], obs_wr[0]); end
      checks++; if (obs_be[0] !== 2'b10) begin failures++; $display("FAIL bs_be got=%b exp=10", obs_be[0]); end
      checks++; if (obs_wd[0] !== 16'hA7A7) begin failures++; $display("FAIL bs_wdata got=%h exp=a7a7", obs_wd[0]); end
      checks++; if (obs_done !== 2 || obs_stall !== 2) begin failures++; $display("FAIL bs_timing got=%0d/%0d exp=2/2", obs_done, obs_stall); end
      checks++; if (obs_ld !== 16'hBEEF) begin failures++; $display("FAIL bs_ld_kept got=%h exp=beef", obs_ld); end
   endtask

   task automatic test_byte_load();
      do_access(1, 0, 1, 0, 16'h1000, 16'h0, 1, 16'h7F80, 0, 16'h0);
      checks++; if (obs_ld !== 16'hFF80) begin failures++; $display("FAIL bl_lo got=%h exp=ff80", obs_ld); end
      checks++; if (obs_done !== 3 || obs_stall !== 3) begin failures++; $display("FAIL bl_timing got=%0d/%0d exp=3/3", obs_done, obs_stall); end
      do_access(1, 0, 1, 0, 16'h1001, 16'h0, 0, 16'h7F80, 0, 16'h0);
      checks++; if (obs_ld !== 16'h007F) begin failures++; $display("FAIL bl_hi got=%h exp=007f", obs_ld); end
      checks++; if (obs_addr[0] !== 16'h1001 || obs_be[0] !== 2'b00) begin failures++; $display("FAIL bl_hi_addr got=%h/%b exp=1001/00", obs_addr[0], obs_be[0]); end
   endtask

   task automatic test_indirect();
      do_access(1, 0, 0, 1, 16'h4000, 16'h0, 1, 16'h5002, 0, 16'h1234);
      checks++; if (obs_addr[0] !== 16'h4000 || obs_addr[1] !== 16'h5002) begin failures++; $display("FAIL ldi_addr got=%h,%h exp=4000,5002", obs_addr[0], obs_addr[1]); end
      checks++; if (obs_ld !== 16'h1234 || obs_nresp !== 2) begin failures++; $display("FAIL ldi_data got=%h/%0d exp=1234/2", obs_ld, obs_nresp); end
      checks++; if (obs_done !== 4 || obs_stall !== 4) begin failures++; $display("FAIL ldi_timing got=%0d/%0d exp=4/4", obs_done, obs_stall); end
      do_access(0, 1, 0, 1, 16'h4001, 16'h55AA, 0, 16'h6001, 1, 16'h0);
      checks++; if (obs_wr[0] !== 1'b0 || obs_addr[0] !== 16'h4000) begin failures++; $display("FAIL sti_ptr got=%b/%h exp=0/4000", obs_wr[0], obs_addr[0]); end
      checks++; if (obs_wr[1] !== 1'b1 || obs_addr[1] !== 16'h6000) begin failures++; $display("FAIL sti_data_addr got=%b/%h exp=1/6000", obs_wr[1], obs_addr[1]); end
      checks++; if (obs_wd[1] !== 16'h55AA || obs_be[1] !== 2'b11) begin failures++; $display("FAIL sti_wdata got=%h/%b exp=55aa/11", obs_wd[1], obs_be[1]); end
      checks++; if (obs_done !== 4 || obs_ld !== 16'h1234) begin failures++; $display("FAIL sti_done got=%0d/%h exp=4/1234", obs_done, obs_ld); end
   endtask

   task automatic test_read_write();
      do_access(1, 1, 0, 0, 16'h0101, 16'hCAFE, 0, 16'h0, 0, 16'h0);
      checks++; if (obs_wr[0] !== 1'b1 || obs_nresp !== 1 || obs_both !== 0) begin failures++; $display("FAIL rw_single_write got=%b/%0d/%0d exp=1/1/0", obs_wr[0], obs_nresp, obs_both); end
      checks++; if (obs_addr[0] !== 16'h0100 || obs_be[0] !== 2'b11 || obs_wd[0] !== 16'hCAFE) begin failures++; $display("FAIL rw_req got=%h/%b/%h exp=0100/11/cafe", obs_addr[0], obs_be[0], obs_wd[0]); end
      checks++; if (obs_ld !== 16'h1234) begin failures++; $display("FAIL rw_ld_kept got=%h exp=1234", obs_ld); end
   endtask

   task automatic test_back_to_back();
      step();
      valid = 1; op_read = 1; addr = 16'h0010;
      @(negedge clk);
      checks++; if (stall !== 1'b1 || dmem_read !== 1'b0) begin failures++; $display("FAIL b2b_t0 got=%b%b exp=10", stall, dmem_read); end
      step();
      checks++; if (dmem_read !== 1'b1) begin failures++; $display("FAIL b2b_req1 got=%b exp=1", dmem_read); end
      dmem_resp = 1; dmem_rdata = 16'h1111;
      step();
      dmem_resp = 0;
      @(negedge clk);
      checks++; if ({load_data_valid, stall, dmem_read} !== 3'b100 || load_data !== 16'h1111) begin failures++; $display("FAIL b2b_done1 got=%b/%h exp=100/1111", {load_data_valid, stall, dmem_read}, load_data); end
      step();
      @(negedge clk);
      checks++; if ({stall, dmem_read, load_data_valid} !== 3'b100) begin failures++; $display("FAIL b2b_retrigger got=%b exp=100", {stall, dmem_read, load_data_valid}); end
      step();
      clear_ops();
      checks++; if (dmem_read !== 1'b1) begin failures++; $display("FAIL b2b_req2 got=%b exp=1", dmem_read); end
      dmem_resp = 1; dmem_rdata = 16'h2222;
      step();
      dmem_resp = 0;
      @(negedge clk);
      checks++; if (load_data_valid !== 1'b1 || load_data !== 16'h2222) begin failures++; $display("FAIL b2b_done2 got=%b/%h exp=1/2222", load_data_valid, load_data); end
      step();
   endtask

   task automatic test_reset_mid();
      step();
      valid = 1; op_read = 1; addr = 16'h0200;
      step();
      clear_ops();
      checks++; if (dmem_read !== 1'b1) begin failures++; $display("FAIL rm_in_data got=%b exp=1", dmem_read); end
      reset = 1; dmem_resp = 1; dmem_rdata = 16'hDEAD;
      step();
      reset = 0; dmem_resp = 0;
      @(negedge clk);
      checks++; if ({dmem_read, dmem_write, stall, load_data_valid} !== 4'b0) begin failures++; $display("FAIL rm_dropped got=%b exp=0000", {dmem_read, dmem_write, stall, load_data_valid}); end
      checks++; if (load_data !== 16'h0) begin failures++; $display("FAIL rm_ld_cleared got=%h exp=0000", load_data); end
      step();
      dmem_resp = 1; dmem_rdata = 16'h9999;
      step();
      dmem_resp = 0;
      @(negedge clk);
      checks++; if (load_data_valid !== 1'b0 || load_data !== 16'h0 || dmem_read !== 1'b0) begin failures++; $display("FAIL stray_resp got=%b/%h/%b exp=0/0000/0", load_data_valid, load_data, dmem_read); end
      step();
      @(negedge clk);
      checks++; if (load_data_valid !== 1'b0) begin failures++; $display("FAIL stray_resp_late got=%b exp=0", load_data_valid); end
   endtask

   initial begin
      test_reset();
      test_non_mem();
      test_word_load();
      test_byte_store();
      test_byte_load();
      test_indirect();
      test_read_write();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
